// File: rtl/ctrl_word_sequencer_pkg.sv
// Shared definitions for the control-word sequencer.
// Holds the FSM state encoding, the position of the "complete" flag
// inside a control word, and the default bus/address widths.
package ctrl_word_sequencer_pkg;

  localparam int CTRL_WIDTH_DEF = 60;
  localparam int PC_WIDTH_DEF   = 8;

  // Bit of a control word that marks it as the final word of a program.
  localparam int CTRL_DONE_BIT  = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/ctrl_word_sequencer_mem.sv
// Program store for the control-word sequencer: simple dual-port RAM.
// One write port for the host and one read port with a single cycle of
// read latency and a read enable, so it maps onto an SRAM macro.
// Ports:
//   clk      - clock
//   we       - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read enable; rd_data holds its value while low
//   rd_addr  - read address
//   rd_data  - registered read data (old contents on a same-edge write)
module ctrl_word_mem #(
  parameter int CTRL_WIDTH = 60,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PC_WIDTH-1:0]   wr_addr,
  input  logic [CTRL_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PC_WIDTH-1:0]   rd_addr,
  output logic [CTRL_WIDTH-1:0] rd_data
);

  logic [CTRL_WIDTH-1:0] mem [2**PC_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Control-word sequencer feeding the LU-decomposition datapath.
// Streams a host-loaded program one word per clock onto CTRL_Signal,
// follows it with DRAIN_CYCLES idle words so in-flight results retire,
// then pulses done. No stalls: the compiled schedule stays cycle-exact.
// Ports:
//   CLK_100     - clock, rising edge
//   RST         - synchronous active-high reset
//   prog_addr   - host write address
//   prog_data   - host write data
//   prog_we     - host write strobe (ignored while busy)
//   prog_len    - number of words to run, sampled with start
//   start       - run request (accepted only in IDLE)
//   abort       - stop the current run immediately
//   CTRL_Signal - registered control word to the datapath
//   busy        - run in progress
//   done        - one-cycle end-of-run pulse
//   pc          - index of the word currently on CTRL_Signal
//   prog_err    - one-cycle pulse when a write or start is rejected
module ctrl_word_sequencer
  import ctrl_word_sequencer_pkg::*;
#(
  parameter int                  CTRL_WIDTH   = CTRL_WIDTH_DEF,
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                  DRAIN_CYCLES = 16,
  parameter logic [CTRL_WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic                  CLK_100,
  input  logic                  RST,
  input  logic [PC_WIDTH-1:0]   prog_addr,
  input  logic [CTRL_WIDTH-1:0] prog_data,
  input  logic                  prog_we,
  input  logic [PC_WIDTH:0]     prog_len,
  input  logic                  start,
  input  logic                  abort,
  output logic [CTRL_WIDTH-1:0] CTRL_Signal,
  output logic                  busy,
  output logic                  done,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  prog_err
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PC_WIDTH:0] LEN_ONE = 1;

  state_t                state;
  logic [PC_WIDTH:0]     cnt;        // index of the word sitting in word_p0
  logic [PC_WIDTH:0]     len;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  rd_en;
  logic [PC_WIDTH-1:0]   rd_addr;
  logic [CTRL_WIDTH-1:0] word_p0;    // memory read stage
  logic                  mem_we;
  logic                  last_word;

  assign mem_we = prog_we && !busy;

  // Word 0 is read on every IDLE edge and held through FETCH, so a host
  // write to address 0 on the start edge is not seen by that run. During
  // RUN the read address runs one word ahead of the emitted word.
  assign rd_en   = (state == ST_IDLE) || (state == ST_RUN);
  assign rd_addr = (state == ST_RUN) ? cnt[PC_WIDTH-1:0] + PC_WIDTH'(1) : '0;

  assign last_word = (cnt == len - LEN_ONE) || word_p0[CTRL_DONE_BIT];

  ctrl_word_mem #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_mem (
    .clk     (CLK_100),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (word_p0)
  );

  // Output stage: CTRL_Signal, pc and status flags
  always_ff @(posedge CLK_100) begin
    if (RST) begin
      state       <= ST_IDLE;
      CTRL_Signal <= IDLE_WORD;
      busy        <= 1'b0;
      done        <= 1'b0;
      pc          <= '0;
      prog_err    <= 1'b0;
      cnt         <= '0;
      len         <= '0;
      drain_cnt   <= '0;
    end else begin
      done     <= (state == ST_DONE);
      prog_err <= (prog_we && busy) || (start && (state != ST_IDLE));

      // DONE is already on its way out, so abort only acts on an active run.
      if (abort && (state inside {ST_FETCH, ST_RUN, ST_DRAIN})) begin
        state       <= ST_DONE;
        CTRL_Signal <= IDLE_WORD;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (prog_len != '0) begin
                len   <= prog_len;
                cnt   <= '0;
                pc    <= '0;
                busy  <= 1'b1;
                state <= ST_FETCH;
              end else begin
                state <= ST_DONE;
              end
            end
          end
          ST_FETCH: begin
            state <= ST_RUN;
          end
          ST_RUN: begin
            CTRL_Signal <= word_p0;
            pc          <= cnt[PC_WIDTH-1:0];
            cnt         <= cnt + LEN_ONE;
            if (last_word) begin
              drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
              state     <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            CTRL_Signal <= IDLE_WORD;
            if (drain_cnt == '0) begin
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
